// File: rtl/data_sram_slave.sv
// ---------------------------------------------------------------------------
// data_sram_slave
//
// Responder end of the CPU data-SRAM interface. It accepts one read or write
// request at a time over a req/addr_ok/data_ok handshake and holds a
// word-organised RAM with byte-lane writes. The response arrives LATENCY
// extra cycles after the minimum two-cycle turnaround.
//
// Parameters
//   AW       word-address width; the RAM holds 2^AW 32-bit words
//   LATENCY  extra wait cycles spent in BUSY before the response (0..15)
//
// Ports
//   clk               clock; all state updates on the rising edge
//   reset             asynchronous, active-high reset
//   cpu_data_req      request valid
//   cpu_data_wr       1 = write, 0 = read
//   cpu_data_size     0 = byte, 1 = half, 2/3 = word
//   cpu_data_addr     byte address; bits above AW+1 are ignored (aliasing)
//   cpu_data_wdata    write data, already lane-aligned by the requester
//   cpu_data_addr_ok  request accepted this cycle when high together with req
//   cpu_data_data_ok  one-cycle response pulse, for reads and writes
//   cpu_data_rdata    last read word; valid when data_ok is high
// ---------------------------------------------------------------------------
module data_sram_slave #(
  parameter int unsigned AW      = 10,
  parameter int unsigned LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic [31:0] cpu_data_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_t          state, state_nxt;
  logic [3:0]      cnt;

  // Request registers captured at accept.
  logic            wr_r;
  logic [AW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic [3:0]      mask_r;

  logic [31:0]     rdata_r;
  logic [3:0]      mask;
  logic            accept;
  logic            commit;

  logic [31:0]     mem [0:(1<<AW)-1];

  // Address bits above the RAM index are intentionally dropped.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^cpu_data_addr[31:AW+2];

  // addr_ok depends on state only, so it never combinationally follows req.
  assign cpu_data_addr_ok = (state == IDLE) || (state == RESP);
  assign cpu_data_data_ok = (state == RESP);
  assign cpu_data_rdata   = rdata_r;

  assign accept = cpu_data_req && cpu_data_addr_ok;
  // The RAM access happens on the edge that leaves BUSY.
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // Lane mask; shifts truncate to 4 bits, so a half at offset 3 keeps lane 3
  // only. Misalignment is the requester's problem to flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mask = 4'b1111;
    case (cpu_data_size)
      2'd0:    mask = 4'b0001 << cpu_data_addr[1:0];
      2'd1:    mask = 4'b0011 << cpu_data_addr[1:0];
      default: mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state   <= IDLE;
      cnt     <= 4'd0;
      wr_r    <= 1'b0;
      idx_r   <= '0;
      wdata_r <= 32'h0;
      mask_r  <= 4'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_r    <= cpu_data_wr;
        idx_r   <= cpu_data_addr[AW+1:2];
        wdata_r <= cpu_data_wdata;
        mask_r  <= mask;
        cnt     <= LAT;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would defeat block-RAM
  // inference. A reset in flight blocks the commit, so a dropped write never
  // lands.
  always_ff @(posedge clk) begin
    if (commit && wr_r && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_r[b]) mem[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
      end
    end
  end

  // rdata only changes on a read commit, so it holds across write responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= 32'h0;
    end else if (commit && !wr_r) begin
      rdata_r <= mem[idx_r];
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_data_sram_slave
//
// Directed bench for data_sram_slave. Two instances share the request fields:
// u_lat0 (LATENCY = 0) and u_lat3 (LATENCY = 3). The sel signal routes req to
// one instance and picks which outputs are observed. Inputs change and outputs
// are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        sel;

  logic        aok0, dok0, aok1, dok1;
  logic [31:0] rd0, rd1;

  logic        aok, dok;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  assign aok   = sel ? aok1 : aok0;
  assign dok   = sel ? dok1 : dok0;
  assign rdata = sel ? rd1  : rd0;

  data_sram_slave #(.AW(10), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset),
    .cpu_data_req(req && !sel), .cpu_data_wr(wr), .cpu_data_size(size),
    .cpu_data_addr(addr), .cpu_data_wdata(wdata),
    .cpu_data_addr_ok(aok0), .cpu_data_data_ok(dok0), .cpu_data_rdata(rd0)
  );

  data_sram_slave #(.AW(10), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset),
    .cpu_data_req(req && sel), .cpu_data_wr(wr), .cpu_data_size(size),
    .cpu_data_addr(addr), .cpu_data_wdata(wdata),
    .cpu_data_addr_ok(aok1), .cpu_data_data_ok(dok1), .cpu_data_rdata(rd1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issues one request from a negedge where addr_ok is expected high, then
  // waits (bounded) for data_ok and checks the turnaround. Returns at the
  // negedge of the response cycle, so a following call is accepted in RESP.
  task automatic txn(input string tag, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d, input int lat,
                     output logic [31:0] rd);
    int n;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    check({tag, " addr_ok"}, 32'(aok), 32'd1);
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (!dok && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(2 + lat));
    rd = rdata;
  endtask

  logic [31:0] rd;
  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp  [3];
  int          stray;

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd2;
    addr = 32'h0; wdata = 32'h0; sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state of both instances.
    check("rst aok0", 32'(aok0), 32'd1);
    check("rst dok0", 32'(dok0), 32'd0);
    check("rst rd0",  rd0, 32'h0);
    check("rst aok1", 32'(aok1), 32'd1);
    check("rst dok1", 32'(dok1), 32'd0);
    check("rst rd1",  rd1, 32'h0);

    // ---- LATENCY = 0 ----
    sel = 1'b0;
    txn("wr10", 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 0, rd);
    txn("rd10", 1'b0, 2'd2, 32'h10, 32'h0, 0, rd);
    check("rd10 data", rd, 32'hDEADBEEF);

    // Byte and half merge into one word.
    txn("wr20", 1'b1, 2'd2, 32'h20, 32'h11223344, 0, rd);
    check("wr20 rdata held", rd, 32'hDEADBEEF);
    txn("wb21", 1'b1, 2'd0, 32'h21, 32'h0000AA00, 0, rd);
    txn("wh22", 1'b1, 2'd1, 32'h22, 32'hBBCC0000, 0, rd);
    txn("rd20", 1'b0, 2'd2, 32'h20, 32'h0, 0, rd);
    check("rd20 merge", rd, 32'hBBCCAA44);

    // Aliasing: 0x1000 is 2^(AW+2) bytes, so it maps onto word 0.
    txn("wr1000", 1'b1, 2'd2, 32'h1000, 32'h0F0F0F0F, 0, rd);
    txn("rd0000", 1'b0, 2'd2, 32'h0000, 32'h0, 0, rd);
    check("alias data", rd, 32'h0F0F0F0F);

    // Misaligned half at offset 3 writes lane 3 only.
    txn("wr40", 1'b1, 2'd2, 32'h40, 32'h44332211, 0, rd);
    txn("wh43", 1'b1, 2'd1, 32'h43, 32'hEE000000, 0, rd);
    txn("rd40", 1'b0, 2'd2, 32'h40, 32'h0, 0, rd);
    check("misaligned half", rd, 32'hEE332211);

    // Back-to-back reads with req held high; accepts at T, T+2, T+4.
    @(negedge clk);  // previous RESP -> IDLE
    b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hDEADBEEF;
    b2b_addr[1] = 32'h20; b2b_exp[1] = 32'hBBCCAA44;
    b2b_addr[2] = 32'h40; b2b_exp[2] = 32'hEE332211;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = b2b_addr[0];
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b%0d accept aok", i), 32'(aok), 32'd1);
      if (i > 0) begin
        check($sformatf("b2b%0d dok", i - 1), 32'(dok), 32'd1);
        check($sformatf("b2b%0d data", i - 1), rdata, b2b_exp[i-1]);
      end
      @(negedge clk);
      check($sformatf("b2b%0d busy aok", i), 32'(aok), 32'd0);
      check($sformatf("b2b%0d busy dok", i), 32'(dok), 32'd0);
      if (i < 2) addr = b2b_addr[i+1];
      else       req  = 1'b0;
      @(negedge clk);
    end
    check("b2b2 dok", 32'(dok), 32'd1);
    check("b2b2 data", rdata, b2b_exp[2]);
    @(negedge clk);
    check("b2b pulse end", 32'(dok), 32'd0);

    // ---- LATENCY = 3 ----
    sel = 1'b1;
    @(negedge clk);
    txn("L3 wr30", 1'b1, 2'd2, 32'h30, 32'h12345678, 3, rd);
    // Read accepted in RESP with req held through BUSY.
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h30;
    check("L3 rd accept aok", 32'(aok), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("L3 T+%0d aok", k), 32'(aok), 32'd0);
      check($sformatf("L3 T+%0d dok", k), 32'(dok), 32'd0);
    end
    @(negedge clk);
    req = 1'b0;
    check("L3 T+5 dok", 32'(dok), 32'd1);
    check("L3 T+5 data", rdata, 32'h12345678);
    @(negedge clk);
    check("L3 idle aok", 32'(aok), 32'd1);

    // Reset in the middle of a write: nothing may commit or respond.
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'h55555555;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst aok", 32'(aok), 32'd1);
    check("midrst dok", 32'(dok), 32'd0);
    check("midrst rdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (dok) stray++;
    end
    check("midrst no data_ok", 32'(stray), 32'd0);
    txn("L3 rd30", 1'b0, 2'd2, 32'h30, 32'h0, 3, rd);
    check("midrst ram kept", rd, 32'h12345678);

    // The LATENCY = 0 instance must keep its RAM across the reset.
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    txn("post rst rd20", 1'b0, 2'd2, 32'h20, 32'h0, 0, rd);
    check("post rst rd20 data", rd, 32'hBBCCAA44);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/data_sram_slave.md
Name: data_sram_slave

Overview:
Responder end of the CPU data-SRAM interface. The memory stage consumes this block's read data; this block is the memory behind it.
- Accepts one read or write request at a time over a req/addr_ok/data_ok handshake.
- Holds a word-organised RAM and applies byte-lane writes.
- Returns the read word after a programmable latency.
- Used as the data-memory model in simulation and as the on-chip data RAM in the SoC.

Parameters:
AW, 10, word-address width; RAM holds 2^AW 32-bit words, indexed by cpu_data_addr[AW+1:2].
LATENCY, 0, extra wait cycles in BUSY before the response; legal range 0..15.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
cpu_data_req  input  1  request valid
cpu_data_wr  input  1  1 = write, 0 = read
cpu_data_size  input  2  0 = byte, 1 = half, 2 = word; 3 treated as word
cpu_data_addr  input  32  byte address
cpu_data_wdata  input  32  write data, lane-aligned by requester
cpu_data_addr_ok  output  1  request accepted this cycle when high together with req
cpu_data_data_ok  output  1  one-cycle response pulse
cpu_data_rdata  output  32  read word, valid when data_ok is high

Behaviour:
- Reset values:
  - state = IDLE, cnt = 0.
  - data_ok = 0, rdata = 32'h0, addr_ok = 1 (combinational from IDLE).
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP.
  - addr_ok = (state == IDLE) || (state == RESP). It is never high in BUSY.
- Accept = req && addr_ok in a cycle. At that edge:
  - capture wr, addr, wdata and the lane mask into request registers;
  - load cnt = LATENCY;
  - state goes to BUSY.
- Lane mask, from size and a = addr[1:0], truncated to 4 bits:
  - size 0: 4'b0001 << a;
  - size 1: 4'b0011 << a;
  - size 2 or 3: 4'b1111.
  - Misaligned requests are not flagged; the requester raises the exception. A misaligned half at a = 3 writes lane 3 only.
- BUSY:
  - If cnt != 0: cnt decrements each edge.
  - If cnt == 0, at the next edge, for a write: update RAM[idx] bytes where mask = 1 from wdata; unmasked bytes are unchanged.
  - If cnt == 0, at the next edge, for a read: load rdata_r = RAM[idx] as a full word. The requester extracts and extends the bytes.
  - State then goes to RESP.
- RESP: data_ok = 1 for exactly this cycle, for both reads and writes.
  - For a write, rdata is the previous value, held.
  - If accept occurs in RESP, state goes to BUSY with the new request; otherwise state goes to IDLE.
- Timing:
  - A request accepted in cycle T gives data_ok in cycle T+2+LATENCY.
  - Maximum back-to-back throughput is one request per 2+LATENCY cycles.
- rdata holds its last read value until the next read response; it never changes outside a RESP entry.
- Ordering: at most one request is outstanding, so a read after a write to the same word returns the merged data.
- req is ignored in BUSY. Requester fields need only be stable in the accept cycle.
- Reset asserted mid-operation:
  - any pending request is dropped, with no data_ok;
  - a write not yet committed (still in BUSY) never reaches the RAM;
  - state returns to IDLE immediately (asynchronous).
- Address bits above AW+1 are ignored, so addresses alias modulo 2^(AW+2) bytes.

Test Plan:
- Word write then read, LATENCY = 0: write addr 0x10, data 0xDEADBEEF accepted at T -> data_ok at T+2. Read 0x10 accepted at T+2 -> data_ok at T+4 with rdata = 0xDEADBEEF.
- Byte and half merge: word 0x11223344 at 0x20; byte write 0xAA at 0x21 (wdata 0x0000AA00); half write 0xBBCC at 0x22 (wdata 0xBBCC0000) -> read 0x20 returns 0xBBCCAA44.
- LATENCY = 3: read accepted at T -> addr_ok low during T+1..T+4, data_ok only at T+5. A req held high in BUSY is not accepted until RESP.
- Back-to-back in RESP: req held continuously for 3 reads -> accepts at T, T+2, T+4. Each data_ok is a single-cycle pulse with the correct word; state never visits IDLE.
- Reset mid-write, LATENCY = 3: write 0x55555555 to 0x30 over old 0x12345678, reset pulsed at T+2 -> no data_ok, addr_ok = 1 after reset, and a read of 0x30 returns 0x12345678.
- Aliasing and misaligned: AW = 10, write 0x0F0F0F0F at 0x1000 -> read 0x0000 returns it. Half write at a = 3 with wdata 0xEE000000 changes byte 3 only.
